// File: rtl/pipe_exc_ctrl.sv
// Pipeline controller: merges stage stall requests, turns mem-stage exceptions
// into a flush/redirect pulse, and keeps a post-flush lockout plus debug counters.
module pipe_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int unsigned LOCKOUT    = 2,
  parameter int unsigned WDOG_MAX   = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        lockout,
  output logic        stall_timeout,
  output logic [15:0] exc_count
);

  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_LOCK    = 1'b1;
  localparam logic [31:0] ERET_CODE = 32'h0000000e;
  localparam logic [3:0]  LOCK_INIT = 4'(LOCKOUT);
  localparam logic [7:0]  WDOG_LIM  = 8'(WDOG_MAX);

  logic [0:0]  r_state;
  logic [3:0]  r_lock_cnt;
  logic [7:0]  r_wdog_cnt;
  logic        r_stall_timeout;
  logic [15:0] r_exc_count;

  logic        w_accept;
  logic [5:0]  w_stall;
  logic [31:0] w_new_pc;

  always_comb begin
    w_accept = (r_state == S_IDLE) && (excepttype_i != '0);
    w_stall  = '0;
    w_new_pc = '0;
    // An accepted exception overrides every stall request in the same cycle.
    if (w_accept) begin
      w_new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end else if (stallreq_mem) begin
      w_stall = 6'b011111;
    end else if (stallreq_ex) begin
      w_stall = 6'b001111;
    end else if (stallreq_id) begin
      w_stall = 6'b000111;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state         <= S_IDLE;
      r_lock_cnt      <= '0;
      r_wdog_cnt      <= '0;
      r_stall_timeout <= 1'b0;
      r_exc_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_LOCK;
            r_lock_cnt <= LOCK_INIT;
            if (r_exc_count != '1) r_exc_count <= r_exc_count + 16'd1;
          end
        end
        default: begin
          r_lock_cnt <= r_lock_cnt - 4'd1;
          if (r_lock_cnt == 4'd1) r_state <= S_IDLE;
        end
      endcase

      // Flag is set on the same edge the counter reaches its limit.
      if (w_stall != '0) begin
        if (r_wdog_cnt != WDOG_LIM) r_wdog_cnt <= r_wdog_cnt + 8'd1;
        if (r_wdog_cnt >= WDOG_LIM - 8'd1) r_stall_timeout <= 1'b1;
      end else begin
        r_wdog_cnt <= '0;
      end
    end
  end

  assign stall         = w_stall;
  assign flush         = w_accept;
  assign new_pc        = w_new_pc;
  assign lockout       = (r_state == S_LOCK);
  assign stall_timeout = r_stall_timeout;
  assign exc_count     = r_exc_count;

endmodule

// File: doc/pipe_exc_ctrl.md
Name: pipe_exc_ctrl

Overview:
Central pipeline controller for the 6-stage core: pc, if, id, ex, mem, wb.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and the stage registers.
- Turns the mem-stage exception type into a one-cycle flush pulse plus redirect address new_pc.
- Sequences a post-flush lockout window.
- Keeps a stall watchdog and an exception event counter for debug.

Parameters:
EXC_VECTOR  32'h00000020  redirect target for every exception except eret
LOCKOUT     2             cycles after a flush during which excepttype_i is ignored (1..15)
WDOG_MAX    255           consecutive stalled cycles that trip the watchdog (1..255)

Ports:
Clk            input   1   clock; all state updates on rising edge
Rst            input   1   synchronous reset, active-high
stallreq_id    input   1   id stage requests stall
stallreq_ex    input   1   ex stage requests stall (multi-cycle op)
stallreq_mem   input   1   mem stage requests stall (slow memory)
excepttype_i   input   32  mem-stage exception code; 0 = none
cp0_epc_i      input   32  current CP0 EPC, used for eret
stall          output  6   bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold
flush          output  1   flush all stage registers, PC loads new_pc
new_pc         output  32  redirect address; valid only while flush=1
lockout        output  1   1 while in LOCK state
stall_timeout  output  1   sticky watchdog flag
exc_count      output  16  saturating count of accepted exceptions

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE, lock counter=0, watchdog counter=0, stall_timeout=0, exc_count=0. Combinational outputs are then stall=0, flush=0, new_pc=0, lockout=0.
- Exception accept: an exception is accepted when state=IDLE and excepttype_i != 0.
- Combinational flush/redirect, zero latency (same cycle as the accept):
  - flush=1; stall=6'b000000 in that cycle.
  - new_pc = cp0_epc_i if excepttype_i==32'h0000000e (eret).
  - new_pc = EXC_VECTOR for any other nonzero code: 0x1 interrupt, 0x8 syscall, 0xa invalid instruction, 0xc overflow, 0xd trap, and unlisted codes.
  - When not flushing, flush=0 and new_pc=0.
- Stall vector when not flushing, highest requesting stage wins:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - no request -> 6'b000000
- FSM states:
  - IDLE: on accept, go to LOCK, load lock counter=LOCKOUT, increment exc_count (saturating at 16'hFFFF).
  - LOCK: lockout=1; excepttype_i is ignored (flush=0); stall requests still honoured. Counter decrements each cycle; at counter==1, return to IDLE on that edge. LOCK therefore lasts exactly LOCKOUT cycles.
- Exceptions take priority over stall requests in the same cycle.
- A nonzero excepttype_i on the first IDLE cycle after LOCK is accepted normally.
- Watchdog:
  - Counter increments each cycle with stall != 0.
  - Counter clears on any cycle with stall==0, including flush cycles.
  - When the counter reaches WDOG_MAX, stall_timeout sets and stays 1 until Rst.
  - Counter saturates at WDOG_MAX.
  - The watchdog has no effect on stall.
- Rst asserted mid-LOCK or mid-stall: next cycle is IDLE with all counters cleared.
- Rst has priority over every other event.

Test Plan:
- Reset, then idle: Rst=1 for 2 cycles, inputs 0 -> stall=0, flush=0, new_pc=0, lockout=0, exc_count=0, stall_timeout=0.
- Stall priority: stallreq_id=1 -> 000111; add stallreq_ex -> 001111; add stallreq_mem -> 011111; release all -> 000000 the same cycle.
- Syscall with concurrent stall: excepttype_i=0x8 and stallreq_ex=1 in cycle N -> cycle N shows flush=1, new_pc=0x00000020, stall=0. Cycles N+1..N+2 show lockout=1. exc_count=1.
- Eret: cp0_epc_i=0x00001234, excepttype_i=0xe -> flush=1, new_pc=0x00001234 in the same cycle.
- Lockout ignore: excepttype_i=0xc held for 4 cycles with LOCKOUT=2 -> flush=1 in cycles 0 and 3 only, exc_count=2.
- Watchdog: WDOG_MAX=4, stallreq_id held 4 cycles -> stall_timeout=1 after the 4th stalled edge and stays 1 after the release. Rst then clears it.
